// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment display blocks.
//   - 4-bit display code constants (0-9 are decimal digits)
//   - 7-bit active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   - is_lead_blank(): true for codes that count as "zero or blank" when
//     leading-zero suppression scans from the most significant digit
// ----------------------------------------------------------------------------
package seg_pkg;

    typedef logic [3:0] seg_code_t;
    typedef logic [6:0] seg_pattern_t;

    localparam seg_code_t SEG_CODE_ZERO   = 4'd0;
    localparam seg_code_t SEG_CODE_MINUS  = 4'd10;
    localparam seg_code_t SEG_CODE_BLANK  = 4'd11;
    localparam seg_code_t SEG_CODE_E      = 4'd12;
    localparam seg_code_t SEG_CODE_R      = 4'd13;
    localparam seg_code_t SEG_CODE_P      = 4'd14;
    localparam seg_code_t SEG_CODE_BLANK2 = 4'd15;

    // Active-low: a 0 bit lights the segment.
    localparam seg_pattern_t SEG_PAT_0     = 7'h40;
    localparam seg_pattern_t SEG_PAT_1     = 7'h79;
    localparam seg_pattern_t SEG_PAT_2     = 7'h24;
    localparam seg_pattern_t SEG_PAT_3     = 7'h30;
    localparam seg_pattern_t SEG_PAT_4     = 7'h19;
    localparam seg_pattern_t SEG_PAT_5     = 7'h12;
    localparam seg_pattern_t SEG_PAT_6     = 7'h02;
    localparam seg_pattern_t SEG_PAT_7     = 7'h78;
    localparam seg_pattern_t SEG_PAT_8     = 7'h00;
    localparam seg_pattern_t SEG_PAT_9     = 7'h10;
    localparam seg_pattern_t SEG_PAT_MINUS = 7'h3F;
    localparam seg_pattern_t SEG_PAT_E     = 7'h06;
    localparam seg_pattern_t SEG_PAT_R     = 7'h2F;
    localparam seg_pattern_t SEG_PAT_P     = 7'h0C;
    localparam seg_pattern_t SEG_PAT_BLANK = 7'h7F;

    function automatic logic is_lead_blank(input seg_code_t code);
        return (code == SEG_CODE_ZERO) || (code == SEG_CODE_BLANK) ||
               (code == SEG_CODE_BLANK2);
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// ----------------------------------------------------------------------------
// seg_decoder
// Combinational 4-bit display code to active-low seven-segment pattern.
// Ports:
//   code     in  4  display code (0-9, 10 minus, 11 blank, 12 E, 13 r,
//                   14 P, 15 blank)
//   segments out 7  active-low {g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_PAT_BLANK;
        case (code)
            4'd0:           segments = SEG_PAT_0;
            4'd1:           segments = SEG_PAT_1;
            4'd2:           segments = SEG_PAT_2;
            4'd3:           segments = SEG_PAT_3;
            4'd4:           segments = SEG_PAT_4;
            4'd5:           segments = SEG_PAT_5;
            4'd6:           segments = SEG_PAT_6;
            4'd7:           segments = SEG_PAT_7;
            4'd8:           segments = SEG_PAT_8;
            4'd9:           segments = SEG_PAT_9;
            SEG_CODE_MINUS: segments = SEG_PAT_MINUS;
            SEG_CODE_E:     segments = SEG_PAT_E;
            SEG_CODE_R:     segments = SEG_PAT_R;
            SEG_CODE_P:     segments = SEG_PAT_P;
            default:        segments = SEG_PAT_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed common-anode seven-segment controller with anti-ghost
// blanking, per-digit enable/blink, leading-zero suppression and
// frame-synchronous (tear-free) updates.
//
// Optional feature macro: SEG_BRIGHTNESS_EN adds a 4-bit brightness input
// that PWM-gates the lit part of each slot.
//
// Ports:
//   clk_in      in   1             system clock
//   reset       in   1             synchronous, active-low reset
//   load        in   1             strobe: capture code/enable/blink to shadow
//   digit_code  in   4*NUM_DIGITS  digit i at [4i+3:4i], digit 0 rightmost
//   digit_en    in   NUM_DIGITS    1 = digit may light
//   blink_mask  in   NUM_DIGITS    1 = digit blinks
//   lz_suppress in   1             1 = blank leading zeros (live)
//   brightness  in   4             (SEG_BRIGHTNESS_EN only) PWM duty, 15=full
//   anode       out  NUM_DIGITS    active-low digit select
//   cathode     out  7             active-low segments {g,f,e,d,c,b,a}
//   frame_done  out  1             pulse during the final cycle of a frame
// ----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digit_code,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_suppress,
`ifdef SEG_BRIGHTNESS_EN
    input  logic [3:0]              brightness,
`endif
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST     = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PRESC_PRE_LAST = PW'(REFRESH_DIV - 2);
    localparam logic [PW-1:0] BLANK_LIMIT    = PW'(BLANK_CYCLES);
    localparam logic [SW-1:0] SLOT_LAST      = SW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST     = BW'(BLINK_DIV - 1);

    // Timing state
    logic [PW-1:0] presc_reg;
    logic [SW-1:0] slot_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic          blink_phase_reg;     // 0 = blinking digits lit
    logic          frame_done_reg;

    // Display data: shadow takes loads, active feeds the scan
    logic [NUM_DIGITS-1:0][3:0] shadow_code_reg;
    logic [NUM_DIGITS-1:0]      shadow_en_reg;
    logic [NUM_DIGITS-1:0]      shadow_blink_reg;
    logic [NUM_DIGITS-1:0][3:0] active_code_reg;
    logic [NUM_DIGITS-1:0]      active_en_reg;
    logic [NUM_DIGITS-1:0]      active_blink_reg;
    logic                       pending_reg;

    logic [NUM_DIGITS-1:0] anode_reg;
    logic [6:0]            cathode_reg;

    // Derived combinational signals
    logic                  presc_wrap;
    logic                  slot_is_last;
    logic                  frame_wrap;
    logic [NUM_DIGITS-1:0] slot_onehot;
    logic [NUM_DIGITS-1:0] suppress;
    logic                  lead_run;
    logic [3:0]            slot_code;
    logic [6:0]            slot_pattern;
    logic                  digit_lit;
    logic                  pwm_on;
    logic [NUM_DIGITS-1:0] anode_next;
    logic [6:0]            cathode_next;

    assign presc_wrap   = (presc_reg == PRESC_LAST);
    assign slot_is_last = (slot_reg == SLOT_LAST);
    assign frame_wrap   = presc_wrap && slot_is_last;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_onehot
            assign slot_onehot[gi] = (slot_reg == SW'(gi));
        end
    endgenerate

    // Walk down from the most significant digit; a digit is suppressed while
    // every digit above it (and itself) is zero/blank. Digit 0 always shows.
    always_comb begin
        lead_run = 1'b1;
        suppress = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead_run    = lead_run & is_lead_blank(active_code_reg[i]);
            suppress[i] = lz_suppress & lead_run;
        end
    end

    assign slot_code = active_code_reg[slot_reg];

    seg_decoder u_decoder (
        .code     (slot_code),
        .segments (slot_pattern)
    );

    assign digit_lit = active_en_reg[slot_reg]
                     & ~(active_blink_reg[slot_reg] & blink_phase_reg)
                     & ~suppress[slot_reg];

`ifdef SEG_BRIGHTNESS_EN
    logic [3:0] presc_lo;
    generate
        if (PW >= 4) begin : g_presc_wide
            assign presc_lo = presc_reg[3:0];
        end else begin : g_presc_narrow
            assign presc_lo = {{(4 - PW){1'b0}}, presc_reg};
        end
    endgenerate
    assign pwm_on = (brightness == 4'hF) || (presc_lo < brightness);
`else
    assign pwm_on = 1'b1;
`endif

    // Segments are driven for a lit digit through the whole slot, including
    // the blanking window, so they settle before the anode turns on.
    always_comb begin
        anode_next   = '1;
        cathode_next = SEG_PAT_BLANK;
        if (digit_lit) begin
            cathode_next = slot_pattern;
            if ((presc_reg >= BLANK_LIMIT) && pwm_on) begin
                anode_next = ~slot_onehot;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            presc_reg        <= '0;
            slot_reg         <= '0;
            blink_cnt_reg    <= '0;
            blink_phase_reg  <= 1'b0;
            frame_done_reg   <= 1'b0;
            shadow_code_reg  <= {NUM_DIGITS{SEG_CODE_BLANK}};
            shadow_en_reg    <= '0;
            shadow_blink_reg <= '0;
            active_code_reg  <= {NUM_DIGITS{SEG_CODE_BLANK}};
            active_en_reg    <= '0;
            active_blink_reg <= '0;
            pending_reg      <= 1'b0;
            anode_reg        <= '1;
            cathode_reg      <= SEG_PAT_BLANK;
        end else begin
            if (presc_wrap) begin
                presc_reg <= '0;
                slot_reg  <= slot_is_last ? '0 : slot_reg + SW'(1);
            end else begin
                presc_reg <= presc_reg + PW'(1);
            end

            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + BW'(1);
            end

            // Registered one cycle early so the pulse lines up with the
            // final cycle of the last slot.
            frame_done_reg <= (presc_reg == PRESC_PRE_LAST) && slot_is_last;

            if (frame_wrap && pending_reg) begin
                active_code_reg  <= shadow_code_reg;
                active_en_reg    <= shadow_en_reg;
                active_blink_reg <= shadow_blink_reg;
                pending_reg      <= 1'b0;
            end

            // A load on the transfer cycle wins: the old shadow moves to
            // active and the new values wait for the next frame.
            if (load) begin
                shadow_code_reg  <= digit_code;
                shadow_en_reg    <= digit_en;
                shadow_blink_reg <= blink_mask;
                pending_reg      <= 1'b1;
            end

            anode_reg   <= anode_next;
            cathode_reg <= cathode_next;
        end
    end

    assign anode      = anode_reg;
    assign cathode    = cathode_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2 blank
// cycles, 64-cycle blink half-period). The reference model derives slot,
// prescaler and blink phase from a cycle count since reset and keeps the
// shadow/active display contents as plain arrays.
// Optional macro SEG_BRIGHTNESS_EN: connects and exercises brightness.
// ----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int BLINK = 64;
    localparam int FRAME = N * DIV;

    logic           clk_in = 1'b0;
    logic           reset  = 1'b0;
    logic           load   = 1'b0;
    logic [4*N-1:0] digit_code = '0;
    logic [N-1:0]   digit_en   = '0;
    logic [N-1:0]   blink_mask = '0;
    logic           lz_suppress = 1'b0;
    logic [3:0]     brightness  = 4'hF;
    logic [N-1:0]   anode;
    logic [6:0]     cathode;
    logic           frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int             t;
    logic [4*N-1:0] m_sh_code, m_ac_code;
    logic [N-1:0]   m_sh_en, m_ac_en, m_sh_bl, m_ac_bl;
    bit             m_pend;

    always #5 clk_in = ~clk_in;

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLANK),
        .BLINK_DIV    (BLINK)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .load        (load),
        .digit_code  (digit_code),
        .digit_en    (digit_en),
        .blink_mask  (blink_mask),
        .lz_suppress (lz_suppress),
`ifdef SEG_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .anode       (anode),
        .cathode     (cathode),
        .frame_done  (frame_done)
    );

    // Glyphs written as lit segments (active-high gfedcba), inverted for pins.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] lit_segs;
        case (code)
            4'd0:  lit_segs = 7'h3F;
            4'd1:  lit_segs = 7'h06;
            4'd2:  lit_segs = 7'h5B;
            4'd3:  lit_segs = 7'h4F;
            4'd4:  lit_segs = 7'h66;
            4'd5:  lit_segs = 7'h6D;
            4'd6:  lit_segs = 7'h7D;
            4'd7:  lit_segs = 7'h07;
            4'd8:  lit_segs = 7'h7F;
            4'd9:  lit_segs = 7'h6F;
            4'd10: lit_segs = 7'h40;
            4'd12: lit_segs = 7'h79;
            4'd13: lit_segs = 7'h50;
            4'd14: lit_segs = 7'h73;
            default: lit_segs = 7'h00;
        endcase
        return ~lit_segs;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        t         = 0;
        m_sh_code = {N{4'd11}};
        m_ac_code = {N{4'd11}};
        m_sh_en   = '0;
        m_ac_en   = '0;
        m_sh_bl   = '0;
        m_ac_bl   = '0;
        m_pend    = 1'b0;
    endtask

    // One clock: predict the outputs from the model, clock, compare, advance.
    task automatic cycle();
        int         presc, slot, phase, br;
        bit         seen, lit, suppressed;
        logic [3:0] code;
        logic [N-1:0] exp_an;
        logic [6:0] exp_cath;
        bit         exp_fd, load_s;

        presc = t % DIV;
        slot  = (t / DIV) % N;
        phase = (t / BLINK) % 2;
        br    = int'(brightness);

        seen = 1'b0;
        suppressed = 1'b0;
        for (int i = N - 1; i >= slot; i--) begin
            code = m_ac_code[4*i +: 4];
            if (!(code == 4'd0 || code == 4'd11 || code == 4'd15)) seen = 1'b1;
        end
        if (lz_suppress && slot != 0 && !seen) suppressed = 1'b1;

        lit = m_ac_en[slot] && !(m_ac_bl[slot] && phase == 1) && !suppressed;
        exp_cath = lit ? glyph(m_ac_code[4*slot +: 4]) : 7'h7F;
        exp_an = '1;
        if (lit && presc >= BLANK && (br == 15 || (presc % 16) < br))
            exp_an = ~(N'(1) << slot);
        exp_fd = (((t + 1) % FRAME) == FRAME - 1);
        load_s = load;

        @(posedge clk_in);
        #1;
        chk("anode", 32'(anode), 32'(exp_an));
        chk("cathode", 32'(cathode), 32'(exp_cath));
        chk("frame_done", 32'(frame_done), 32'(exp_fd));

        if ((t % FRAME) == FRAME - 1 && m_pend) begin
            m_ac_code = m_sh_code;
            m_ac_en   = m_sh_en;
            m_ac_bl   = m_sh_bl;
            m_pend    = 1'b0;
        end
        if (load_s) begin
            m_sh_code = digit_code;
            m_sh_en   = digit_en;
            m_sh_bl   = blink_mask;
            m_pend    = 1'b1;
        end
        t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_to(input int modulus, input int value);
        for (int i = 0; i < modulus && (t % modulus) != value; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk_in);
        #1;
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_cathode", 32'(cathode), 32'h7F);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        model_reset();
        reset = 1'b1;
        $display("reset applied");
    endtask

    task automatic do_load(input logic [4*N-1:0] code, input logic [N-1:0] en,
                           input logic [N-1:0] bl);
        digit_code = code;
        digit_en   = en;
        blink_mask = bl;
        load       = 1'b1;
        $display("load t=%0d code=%h en=%b blink=%b lz=%0b", t, code, en, bl, lz_suppress);
        cycle();
        load = 1'b0;
    endtask

    initial begin
        logic [4*N-1:0] rc;
        model_reset();

        // Reset held for a few edges, then free-running scan with nothing lit
        do_reset();
        reset = 1'b0;
        do_reset();
        run(40);

        // Mid-frame load: old (blank) display until the frame boundary
        run_to(FRAME, 10);
        do_load({4'd3, 4'd0, 4'd0, 4'd7}, 4'hF, 4'h0);
        run(70);

        // Leading-zero suppression
        lz_suppress = 1'b1;
        do_load({4'd0, 4'd0, 4'd0, 4'd0}, 4'hF, 4'h0);
        run(70);
        do_load({4'd10, 4'd0, 4'd4, 4'd2}, 4'hF, 4'h0);
        run(70);
        do_load({4'd11, 4'd0, 4'd15, 4'd0}, 4'hF, 4'h0);
        run(40);
        lz_suppress = 1'b0;
        run(40);

        // Blink on digit 0 only, spanning several blink half-periods
        do_load({4'd12, 4'd13, 4'd14, 4'd9}, 4'hF, 4'b0001);
        run(280);

        // Load on the frame_done cycle is deferred one full frame
        run_to(FRAME, FRAME - 1);
        do_load({4'd5, 4'd6, 4'd8, 4'd1}, 4'hF, 4'h0);
        run(FRAME + 40);

        // Repeated loads within a frame: last one wins
        run_to(FRAME, 4);
        do_load({4'd1, 4'd1, 4'd1, 4'd1}, 4'hF, 4'h0);
        run(3);
        do_load({4'd2, 4'd4, 4'd6, 4'd8}, 4'b1010, 4'h0);
        run(70);

        // Randomized loads, enables, blink masks and live lz_suppress
        for (int k = 0; k < 24; k++) begin
            for (int d = 0; d < N; d++) begin
                rc[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            lz_suppress = 1'($urandom_range(0, 1));
            run($urandom_range(0, 40));
            do_load(rc, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        run(80);

        // Reset mid-slot, then verify scan restarts at slot 0
        run_to(DIV, 5);
        do_reset();
        run(40);
        lz_suppress = 1'b0;
        do_load({4'd4, 4'd3, 4'd2, 4'd1}, 4'hF, 4'h0);
        run(80);

`ifdef SEG_BRIGHTNESS_EN
        brightness = 4'd4;
        run(70);
        brightness = 4'd0;
        run(40);
        brightness = 4'hF;
        run(40);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
